// File: rtl/lockout_ctrl.sv
// Password-entry lockout controller: counts consecutive failures, starts a lockout
// countdown after MAX_TRIES, and escalates to a latched alarm after LOCK_ROUNDS lockouts.
module lockout_ctrl #(
   parameter int unsigned MAX_TRIES   = 3,
   parameter int unsigned LOCK_ROUNDS = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pass_ok,
   input  logic       pass_fail,
   input  logic       cd_done,
   input  logic       admin_clr,
   output logic       cd_start,
   output logic       locked,
   output logic       unlock,
   output logic       alarm,
   output logic [1:0] fail_cnt,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StStart  = 2'b01,
      StLocked = 2'b10,
      StAlarm  = 2'b11
   } state_e;

   localparam logic [1:0] MaxTries   = 2'(MAX_TRIES);
   localparam logic [1:0] LockRounds = 2'(LOCK_ROUNDS);

   state_e     r_state;
   logic [1:0] r_fail_cnt;
   logic [1:0] r_lock_cnt;
   logic       r_cd_start;
   logic       r_locked;
   logic       r_unlock;
   logic       r_alarm;
   logic       r_lk_first;

   logic [1:0] w_fail_inc;
   logic [1:0] w_lock_inc;

   assign w_fail_inc = (r_fail_cnt >= MaxTries) ? r_fail_cnt : r_fail_cnt + 2'd1;
   assign w_lock_inc = (r_lock_cnt == 2'd3)     ? r_lock_cnt : r_lock_cnt + 2'd1;

   always_ff @(posedge clk) begin
      if (rst || admin_clr) begin
         r_state    <= StIdle;
         r_fail_cnt <= 2'd0;
         r_lock_cnt <= 2'd0;
         r_cd_start <= 1'b0;
         r_locked   <= 1'b0;
         r_unlock   <= 1'b0;
         r_alarm    <= 1'b0;
         r_lk_first <= 1'b0;
      end else begin
         r_cd_start <= 1'b0;
         r_unlock   <= 1'b0;
         case (r_state)
            StIdle: begin
               // A simultaneous ok+fail counts as a failure only.
               if (pass_fail) begin
                  r_fail_cnt <= w_fail_inc;
                  if (w_fail_inc >= MaxTries) begin
                     r_lock_cnt <= w_lock_inc;
                     r_locked   <= 1'b1;
                     if (w_lock_inc >= LockRounds) begin
                        r_state <= StAlarm;
                        r_alarm <= 1'b1;
                     end else begin
                        r_state    <= StStart;
                        r_cd_start <= 1'b1;
                     end
                  end
               end else if (pass_ok) begin
                  r_unlock   <= 1'b1;
                  r_fail_cnt <= 2'd0;
                  r_lock_cnt <= 2'd0;
               end
            end
            StStart: begin
               r_state    <= StLocked;
               r_lk_first <= 1'b1;
            end
            StLocked: begin
               // cd_done may still be high from the previous countdown; skip one cycle.
               if (r_lk_first) begin
                  r_lk_first <= 1'b0;
               end else if (cd_done) begin
                  r_state    <= StIdle;
                  r_fail_cnt <= 2'd0;
                  r_locked   <= 1'b0;
               end
            end
            StAlarm: begin
               r_state <= StAlarm;
            end
         endcase
      end
   end

   assign cd_start = r_cd_start;
   assign locked   = r_locked;
   assign unlock   = r_unlock;
   assign alarm    = r_alarm;
   assign fail_cnt = r_fail_cnt;
   assign state    = r_state;

endmodule

// File: tb/tb_lockout_ctrl.sv
// Directed bench for lockout_ctrl: default instance plus a MAX_TRIES=1/LOCK_ROUNDS=1 instance.
// Observed vector layout: {cd_start, locked, unlock, alarm, fail_cnt[1:0], state[1:0]}.
module tb_lockout_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pass_ok = 1'b0;
   logic       pass_fail = 1'b0;
   logic       cd_done = 1'b0;
   logic       admin_clr = 1'b0;

   logic       cd_start0, locked0, unlock0, alarm0;
   logic [1:0] fail_cnt0, state0;
   logic       cd_start1, locked1, unlock1, alarm1;
   logic [1:0] fail_cnt1, state1;
   logic [7:0] obs0, obs1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   lockout_ctrl u_dut (
      .clk       (clk),
      .rst       (rst),
      .pass_ok   (pass_ok),
      .pass_fail (pass_fail),
      .cd_done   (cd_done),
      .admin_clr (admin_clr),
      .cd_start  (cd_start0),
      .locked    (locked0),
      .unlock    (unlock0),
      .alarm     (alarm0),
      .fail_cnt  (fail_cnt0),
      .state     (state0)
   );

   lockout_ctrl #(
      .MAX_TRIES   (1),
      .LOCK_ROUNDS (1)
   ) u_dut_min (
      .clk       (clk),
      .rst       (rst),
      .pass_ok   (pass_ok),
      .pass_fail (pass_fail),
      .cd_done   (cd_done),
      .admin_clr (admin_clr),
      .cd_start  (cd_start1),
      .locked    (locked1),
      .unlock    (unlock1),
      .alarm     (alarm1),
      .fail_cnt  (fail_cnt1),
      .state     (state1)
   );

   assign obs0 = {cd_start0, locked0, unlock0, alarm0, fail_cnt0, state0};
   assign obs1 = {cd_start1, locked1, unlock1, alarm1, fail_cnt1, state1};

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Drive one cycle of pulse inputs, then sample 1ns after the edge.
   task automatic cyc(input logic ok, input logic fail, input logic clr, input logic r);
      pass_ok   = ok;
      pass_fail = fail;
      admin_clr = clr;
      rst       = r;
      @(posedge clk);
      #1;
      pass_ok   = 1'b0;
      pass_fail = 1'b0;
      admin_clr = 1'b0;
      rst       = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      cyc(0, 0, 0, 1);
      check("reset", obs0, 8'b0000_0000);

      // fail, fail, ok
      cyc(0, 1, 0, 0); check("fail1", obs0, 8'b0000_0100);
      cyc(0, 1, 0, 0); check("fail2", obs0, 8'b0000_1000);
      cyc(1, 0, 0, 0); check("ok_unlock", obs0, 8'b0010_0000);
      cyc(0, 0, 0, 0); check("unlock_1cyc", obs0, 8'b0000_0000);

      // first lockout, cd_done already high before start
      cd_done = 1'b1;
      cyc(0, 1, 0, 0); check("r1_fail1", obs0, 8'b0000_0100);
      cyc(0, 1, 0, 0); check("r1_fail2", obs0, 8'b0000_1000);
      cyc(0, 1, 0, 0); check("r1_start", obs0, 8'b1100_1101);
      cyc(1, 0, 0, 0); check("r1_locked", obs0, 8'b0100_1110);
      cyc(1, 1, 0, 0); check("r1_stale_cd", obs0, 8'b0100_1110);
      cyc(0, 0, 0, 0); check("r1_release", obs0, 8'b0000_0000);

      // second lockout without ok -> alarm
      cyc(0, 1, 0, 0); check("r2_fail1", obs0, 8'b0000_0100);
      cyc(0, 1, 0, 0); check("r2_fail2", obs0, 8'b0000_1000);
      cyc(0, 1, 0, 0); check("r2_alarm", obs0, 8'b0101_1111);
      cyc(1, 0, 0, 0); check("alarm_hold_ok", obs0, 8'b0101_1111);
      cyc(0, 1, 0, 0); check("alarm_hold_fail", obs0, 8'b0101_1111);
      cyc(0, 0, 0, 0); check("alarm_hold_cd", obs0, 8'b0101_1111);
      cyc(0, 0, 1, 0); check("admin_clr", obs0, 8'b0000_0000);

      // lockout count was cleared: next third fail must start, not alarm
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0); check("post_clr_start", obs0, 8'b1100_1101);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0); check("post_clr_release", obs0, 8'b0000_0000);
      cyc(0, 0, 1, 0);

      // ok+fail together at fail_cnt=2
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(1, 1, 0, 0); check("both_is_fail", obs0, 8'b1100_1101);
      cyc(0, 0, 0, 0); check("both_locked", obs0, 8'b0100_1110);

      // rst while locked
      cyc(0, 0, 0, 1); check("rst_locked", obs0, 8'b0000_0000);
      cyc(0, 0, 0, 0); check("rst_no_pulse", obs0, 8'b0000_0000);

      // rst cleared lockout count: third fail starts rather than alarms
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0); check("rst_cnt_clr", obs0, 8'b1100_1101);

      // rst with admin_clr and a fail in the same cycle
      cyc(0, 0, 0, 1);
      cyc(0, 1, 0, 0); check("pre_rst_clr", obs0, 8'b0000_0100);
      cyc(0, 1, 1, 1); check("rst_and_clr", obs0, 8'b0000_0000);

      // MAX_TRIES=1, LOCK_ROUNDS=1: one fail goes straight to alarm
      cyc(0, 0, 0, 1); check("min_reset", obs1, 8'b0000_0000);
      cyc(0, 1, 0, 0); check("min_alarm", obs1, 8'b0101_0111);
      cyc(0, 0, 0, 0); check("min_alarm_hold", obs1, 8'b0101_0111);
      cyc(0, 0, 1, 0); check("min_clr", obs1, 8'b0000_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lockout_ctrl.md
LOCKOUT_CTRL -- requirements
Module: lockout_ctrl

Interface
REQ-001 SHALL have parameter MAX_TRIES, default 3, meaning consecutive wrong entries that trigger a lockout (legal 1..3).
REQ-002 SHALL have parameter LOCK_ROUNDS, default 2, meaning lockouts without a correct entry that escalate to alarm (legal 1..3).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port pass_ok  input  1  one-cycle pulse: entered password matched.
REQ-006 SHALL have port pass_fail  input  1  one-cycle pulse: entered password mismatched.
REQ-007 SHALL have port cd_done  input  1  level from the 3-to-0 lockout countdown: high once it has expired.
REQ-008 SHALL have port admin_clr  input  1  one-cycle pulse: supervisor clear.
REQ-009 SHALL have port cd_start  output  1  one-cycle pulse that reloads and starts the lockout countdown (drives its lock input).
REQ-010 SHALL have port locked  output  1  high while entries are refused.
REQ-011 SHALL have port unlock  output  1  one-cycle pulse on an accepted correct entry.
REQ-012 SHALL have port alarm  output  1  high in ALARM state.
REQ-013 SHALL have port fail_cnt  output  2  current consecutive-failure count.
REQ-014 SHALL have port state  output  2  FSM state encoding: IDLE=00, START=01, LOCKED=10, ALARM=11.

Function
REQ-015 All outputs SHALL be registered; no combinational input-to-output path.
REQ-016 Priority SHALL be rst > admin_clr > all other inputs.
REQ-017 IDLE, pass_ok alone: unlock=1 next cycle, fail_cnt->0, lockout count->0, stay IDLE.
REQ-018 IDLE, pass_fail: fail_cnt increments; if the new value < MAX_TRIES, stay IDLE.
REQ-019 IDLE, pass_fail making fail_cnt reach MAX_TRIES: lockout count increments; if the new count == LOCK_ROUNDS go ALARM, else go START.
REQ-020 Simultaneous pass_ok and pass_fail SHALL be treated as pass_fail only (no unlock).
REQ-021 START SHALL last exactly one cycle with cd_start=1, locked=1, then go LOCKED.
REQ-022 LOCKED: locked=1; pass_ok/pass_fail ignored (no unlock, fail_cnt held at MAX_TRIES).
REQ-023 LOCKED SHALL ignore cd_done in its first cycle (stale expiry guard); thereafter cd_done=1 -> IDLE with fail_cnt=0, lockout count retained.
REQ-024 ALARM: alarm=1, locked=1, all entries ignored, cd_done ignored, cd_start never pulses; exit only via admin_clr or rst.
REQ-025 admin_clr in any state -> IDLE next cycle, fail_cnt=0, lockout count=0, alarm=0, locked=0, no unlock pulse.
REQ-026 Counters SHALL saturate, never wrap; fail_cnt never exceeds MAX_TRIES.
REQ-027 cd_start and unlock SHALL each be high for at most one consecutive cycle.

Reset
REQ-028 On rst: state=IDLE, fail_cnt=0, lockout count=0, cd_start=0, locked=0, unlock=0, alarm=0.
REQ-029 rst mid-LOCKED or mid-ALARM SHALL abandon the lockout with no cd_start or unlock pulse.

Verification
REQ-030 Defaults; fail, fail, ok -> fail_cnt 1,2 then 0, unlock one pulse, locked stays 0.
REQ-031 3x pass_fail -> cd_start pulse 1 cycle, state 01 then 10, locked=1; pass_ok while locked -> no unlock; cd_done=1 (held high from before start) -> ignored in first LOCKED cycle, then IDLE, fail_cnt=0.
REQ-032 Two full lockout rounds with no pass_ok -> second 3rd fail goes to state 11, alarm=1, no cd_start; cd_done=1 -> stays ALARM; admin_clr -> IDLE, all clear.
REQ-033 pass_ok and pass_fail same cycle at fail_cnt=2 -> lockout entered, no unlock.
REQ-034 rst asserted during LOCKED and admin_clr with rst same cycle -> all outputs at reset values next cycle.
REQ-035 MAX_TRIES=1, LOCK_ROUNDS=1 -> single pass_fail goes straight to ALARM.
